// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch stage of the unpipelined core.
// It holds the PC and fetches one word over a req/ack handshake. The word is held
// for decode/execute. On instr_done the next PC is selected with this priority:
// register target, then jump target, then branch target, then PC+4.
// Optional macro PC_ALIGN_CHECK_EN: a misaligned target redirects to EXC_VECTOR
// and pulses misalign_err. Without it, target bits [1:0] are cleared before loading.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_done,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jump_reg,
   input  logic [31:0] jump_reg_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] retired_count,
   output logic        misalign_err
);

   localparam logic [0:0] ST_FETCH = 1'b0;
   localparam logic [0:0] ST_EXEC  = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] retired_q, retired_d;
   logic        misalign_q, misalign_d;
   logic [31:0] next_pc;

`ifndef PC_ALIGN_CHECK_EN
   // The exception vector is only meaningful when alignment checking is built in.
   logic unused_exc_vector;
   assign unused_exc_vector = ^EXC_VECTOR;
`endif

   assign pc_plus4 = pc_q + 32'd4;

   // Next-PC candidate selection; the highest-priority source wins silently.
   always_comb begin
      next_pc = pc_plus4;
      if (jump_reg) begin
         next_pc = jump_reg_addr;
      end else if (jump) begin
         next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      end else if (branch_taken) begin
         next_pc = pc_plus4 + branch_offset;
      end
   end

   // Fetch/execute sequencing and the next-state values of every register.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      retired_d     = retired_q;
      misalign_d    = 1'b0;
      if (state_q == ST_FETCH) begin
         if (imem_ack) begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = ST_EXEC;
         end
      end else begin
         if (instr_done) begin
            instr_valid_d = 1'b0;
            retired_d     = retired_q + 32'd1;
            state_d       = ST_FETCH;
`ifdef PC_ALIGN_CHECK_EN
            if (next_pc[1:0] != 2'b00) begin
               pc_d       = EXC_VECTOR;
               misalign_d = 1'b1;
            end else begin
               pc_d = next_pc;
            end
`else
            pc_d = next_pc & ~32'h0000_0003;
`endif
         end
      end
   end

   // State registers; reset has priority and abandons any outstanding fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_VECTOR;
         instr_q       <= 32'd0;
         instr_valid_q <= 1'b0;
         retired_q     <= 32'd0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         retired_q     <= retired_d;
         misalign_q    <= misalign_d;
      end
   end

   assign imem_req      = (state_q == ST_FETCH);
   assign imem_addr     = pc_q;
   assign pc            = pc_q;
   assign instr         = instr_q;
   assign instr_valid   = instr_valid_q;
   assign retired_count = retired_q;
   assign misalign_err  = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit. It runs a table of directed instructions, a reset
// taken in the middle of a fetch, and randomized instructions. Expected values
// come from a transaction-level next-PC model. Follows PC_ALIGN_CHECK_EN like the DUT.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_done = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_offset = 32'd0;
   logic        jump = 1'b0;
   logic [25:0] jump_index = 26'd0;
   logic        jump_reg = 1'b0;
   logic [31:0] jump_reg_addr = 32'd0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] retired_count;
   logic        misalign_err;

`ifdef PC_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   pc_fetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .instr_done(instr_done),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_index(jump_index),
      .jump_reg(jump_reg), .jump_reg_addr(jump_reg_addr),
      .pc(pc), .pc_plus4(pc_plus4),
      .retired_count(retired_count), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_pc;
   logic [31:0] m_ret;

   typedef struct {
      int          aw;
      logic [31:0] rd;
      int          dw;
      logic        br;
      logic [31:0] off;
      logic        j;
      logic [25:0] idx;
      logic        jr;
      logic [31:0] jra;
      logic [31:0] exp_pc;
      logic        exp_err;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int aw, input logic [31:0] rd, input int dw,
                               input logic br, input logic [31:0] off, input logic j,
                               input logic [25:0] idx, input logic jr, input logic [31:0] jra,
                               input logic [31:0] exp_pc, input logic exp_err);
      vec_t v;
      v.aw = aw; v.rd = rd; v.dw = dw; v.br = br; v.off = off; v.j = j;
      v.idx = idx; v.jr = jr; v.jra = jra; v.exp_pc = exp_pc; v.exp_err = exp_err;
      return v;
   endfunction

   // Next PC from the architectural rules, with plain arithmetic.
   task automatic ref_next(input logic [31:0] cur, input logic br, input logic [31:0] off,
                           input logic j, input logic [25:0] idx, input logic jr,
                           input logic [31:0] jra, output logic [31:0] npc, output logic err);
      logic [31:0] seq;
      logic [31:0] tgt;
      seq = cur + 32'd4;
      if (jr)      tgt = jra;
      else if (j)  tgt = (seq & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
      else if (br) tgt = seq + off;
      else         tgt = seq;
      err = 1'b0;
      if (tgt % 4 != 0) begin
         if (ALIGN_EN) begin
            npc = 32'h0000_0080;
            err = 1'b1;
         end else begin
            npc = tgt - (tgt % 4);
         end
      end else begin
         npc = tgt;
      end
   endtask

   task automatic noise();
      logic [31:0] r;
      r = $urandom;
      branch_taken  = r[0];
      jump          = r[1];
      jump_reg      = r[2];
      branch_offset = $urandom;
      jump_reg_addr = $urandom;
      r = $urandom;
      jump_index    = r[25:0];
   endtask

   task automatic quiet();
      instr_done = 1'b0; branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
   endtask

   // One full instruction: fetch with aw wait states, execute for dw extra cycles, retire.
   task automatic do_instr(input int aw, input logic [31:0] rd, input int dw,
                           input logic br, input logic [31:0] off, input logic j,
                           input logic [25:0] idx, input logic jr, input logic [31:0] jra,
                           input logic [31:0] exp_pc, input logic exp_err);
      logic [31:0] r;
      for (int w = 0; w < aw; w++) begin
         chk("wait_req", 32'(imem_req), 32'd1);
         chk("wait_addr", imem_addr, m_pc);
         chk("wait_valid", 32'(instr_valid), 32'd0);
         imem_ack = 1'b0;
         r = $urandom;
         instr_done = r[0];
         noise();
         @(negedge clk);
      end
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      imem_ack = 1'b1;
      imem_rdata = rd;
      quiet();
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      chk("exec_valid", 32'(instr_valid), 32'd1);
      chk("exec_instr", instr, rd);
      chk("exec_req", 32'(imem_req), 32'd0);
      chk("exec_pc", pc, m_pc);
      chk("misalign_idle", 32'(misalign_err), 32'd0);
      for (int d = 0; d < dw; d++) begin
         imem_ack = 1'b1;
         imem_rdata = ~rd;
         noise();
         instr_done = 1'b0;
         @(negedge clk);
         imem_ack = 1'b0;
         chk("hold_instr", instr, rd);
         chk("hold_valid", 32'(instr_valid), 32'd1);
         chk("hold_pc", pc, m_pc);
      end
      instr_done = 1'b1;
      branch_taken = br; branch_offset = off; jump = j; jump_index = idx;
      jump_reg = jr; jump_reg_addr = jra;
      @(negedge clk);
      quiet();
      m_pc = exp_pc;
      m_ret = m_ret + 32'd1;
      chk("next_pc", pc, m_pc);
      chk("retired", retired_count, m_ret);
      chk("misalign", 32'(misalign_err), 32'(exp_err));
      chk("refetch_req", 32'(imem_req), 32'd1);
      chk("done_valid", 32'(instr_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] npc;
      logic        err;
      logic [31:0] r;
      logic [31:0] off;
      logic [31:0] jra;
      logic [31:0] idx32;
      logic        br;
      logic        j;
      logic        jr;

      tbl[0]  = mk(0, 32'h2002_0005, 0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 32'h0000_0004, 0);
      tbl[1]  = mk(1, 32'h1111_1111, 1, 0, 32'd0, 0, 26'd0, 0, 32'd0, 32'h0000_0008, 0);
      tbl[2]  = mk(3, 32'h2222_2222, 2, 0, 32'd0, 0, 26'd0, 0, 32'd0, 32'h0000_000C, 0);
      tbl[3]  = mk(0, 32'h3333_3333, 0, 0, 32'd0, 0, 26'd0, 1, 32'h0000_0040, 32'h0000_0040, 0);
      tbl[4]  = mk(0, 32'h4444_4444, 0, 1, 32'hFFFF_FFF0, 0, 26'd0, 0, 32'd0, 32'h0000_0034, 0);
      tbl[5]  = mk(0, 32'h5555_5555, 0, 0, 32'd0, 0, 26'd0, 1, 32'h1000_0000, 32'h1000_0000, 0);
      tbl[6]  = mk(0, 32'h6666_6666, 1, 1, 32'h0000_0040, 1, 26'h000_0100, 0, 32'd0, 32'h1000_0400, 0);
      tbl[7]  = mk(0, 32'h7777_7777, 0, 1, 32'h0000_0040, 1, 26'h000_0100, 1, 32'h0000_0200, 32'h0000_0200, 0);
      tbl[8]  = mk(0, 32'h8888_8888, 0, 0, 32'd0, 0, 26'd0, 1, 32'h0000_0102,
                   ALIGN_EN ? 32'h0000_0080 : 32'h0000_0100, ALIGN_EN);
      tbl[9]  = mk(0, 32'h9999_9999, 0, 0, 32'd0, 0, 26'd0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
      tbl[10] = mk(2, 32'hAAAA_AAAA, 0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 32'h0000_0000, 0);
      tbl[11] = mk(0, 32'hBBBB_BBBB, 0, 0, 32'd0, 0, 26'd0, 1, 32'h0000_0020, 32'h0000_0020, 0);

      // Reset for two cycles with noisy inputs, then release.
      rst = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      @(negedge clk);
      imem_ack = 1'b0;
      chk("rst_pc", pc, 32'h0000_0000);
      chk("rst_instr", instr, 32'h0000_0000);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_retired", retired_count, 32'd0);
      chk("rst_misalign", 32'(misalign_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req", 32'(imem_req), 32'd1);
      chk("post_rst_addr", imem_addr, 32'h0000_0000);
      m_pc = 32'd0;
      m_ret = 32'd0;

      for (int i = 0; i < 12; i++) begin
         do_instr(tbl[i].aw, tbl[i].rd, tbl[i].dw, tbl[i].br, tbl[i].off, tbl[i].j,
                  tbl[i].idx, tbl[i].jr, tbl[i].jra, tbl[i].exp_pc, tbl[i].exp_err);
      end

      // Reset while fetching at 0x20; an ack during reset is dropped and the
      // ack in the first cycle after release fetches from address 0.
      chk("pre_rst_pc", pc, 32'h0000_0020);
      rst = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("mid_rst_pc", pc, 32'h0000_0000);
      chk("mid_rst_retired", retired_count, 32'd0);
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      rst = 1'b0;
      m_pc = 32'd0;
      m_ret = 32'd0;
      do_instr(0, 32'h1234_5678, 0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 32'h0000_0004, 0);

      // Randomized instructions checked against the reference model.
      for (int n = 0; n < 200; n++) begin
         r = $urandom;
         br = r[0];
         j  = (r[3:2] == 2'b00);
         jr = (r[5:4] == 2'b00);
         off = $urandom;
         if (r[6]) off[1:0] = 2'b00;
         jra = $urandom;
         if (r[7]) jra[1:0] = 2'b00;
         idx32 = $urandom;
         ref_next(m_pc, br, off, j, idx32[25:0], jr, jra, npc, err);
         do_instr(int'(r[9:8]), $urandom, int'(r[11:10]), br, off, j, idx32[25:0], jr, jra, npc, err);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the unpipelined processor.
- Holds the PC, fetches one instruction from instruction memory over a req/ack handshake, and presents it to decode/execute.
- When the core signals completion, selects the next PC from PC+4, branch target, jump target or register target.
- Consumes the already-shifted branch offset produced by the shift-left-2 block; forms the jump target from the raw 26-bit index itself.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on a misaligned target (only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory accepted the request; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  latched instruction for decode.
- instr_valid  out  1  instr is valid and executing.
- instr_done  in  1  core finished the current instruction; next-PC controls valid this cycle.
- branch_taken  in  1  take the branch.
- branch_offset  in  32  sign-extended immediate, already shifted left 2.
- jump  in  1  J/JAL.
- jump_index  in  26  instr[25:0] for J/JAL.
- jump_reg  in  1  JR/JALR.
- jump_reg_addr  in  32  register target.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4 (combinational, mod 2^32).
- retired_count  out  32  instructions retired since reset.
- misalign_err  out  1  one-cycle pulse on a misaligned target.

Behaviour:
- Only clk and rst are used; rst is synchronous, active-high, and has priority over everything.
- Reset values:
  - pc = RESET_VECTOR
  - state = FETCH
  - instr = 0
  - instr_valid = 0
  - retired_count = 0
  - misalign_err = 0
  - imem_req is 1 from the first cycle after rst deasserts.
- State FETCH:
  - imem_req = 1; imem_addr = pc, held stable until ack.
  - If imem_ack: instr <= imem_rdata, instr_valid <= 1, go to EXEC.
  - Otherwise stay in FETCH with request held; there is no timeout.
- State EXEC:
  - imem_req = 0; instr and instr_valid are held.
  - If instr_done: pc <= next_pc, instr_valid <= 0, retired_count <= retired_count + 1 (wraps at 2^32), go to FETCH.
  - Otherwise hold.
- Next-PC priority: jump_reg > jump > branch_taken > sequential.
  - jump_reg: jump_reg_addr.
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - branch_taken: pc_plus4 + branch_offset, 32-bit wrap, carry discarded.
  - Otherwise: pc_plus4. 32'hFFFF_FFFC + 4 wraps to 0.
- Simultaneous controls: the higher-priority source wins silently; no error is raised.
- Ignored inputs:
  - imem_ack outside FETCH.
  - instr_done outside EXEC.
  - Next-PC controls when instr_done = 0.
- Latency:
  - ack in cycle N gives instr_valid = 1 in N+1.
  - instr_done in cycle M gives the new pc and imem_req = 1 in M+1.
  - Minimum 2 cycles per instruction (zero-wait memory, instr_done asserted on the first EXEC cycle).
- Reset mid-fetch or mid-execute: the outstanding request is abandoned and the late ack is ignored because the state is FETCH with the new address. pc returns to RESET_VECTOR; retired_count clears.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - If the selected next_pc[1:0] != 0 on instr_done, pc <= EXC_VECTOR instead.
  - misalign_err = 1 for exactly the following cycle.
  - The instruction still counts as retired.
- Undefined:
  - next_pc[1:0] is forced to 2'b00 before loading.
  - misalign_err is tied 0; the port remains present.

Test Plan:
- Reset and sequential run: assert rst 2 cycles, release; ack immediately with 32'h2002_0005 → imem_addr = 0, instr_valid next cycle. instr_done with no controls → pc = 4, retired_count = 1, imem_req = 1.
- Wait-state fetch: hold imem_ack low 3 cycles at pc = 8 → imem_req and imem_addr = 8 stable all 3 cycles; instr_valid rises the cycle after ack. A stray ack during EXEC has no effect.
- Branch backward: pc = 32'h0000_0040, branch_taken = 1, branch_offset = 32'hFFFF_FFF0 → pc = 32'h0000_0034.
- Jump and priority: pc = 32'h1000_0000, jump = 1, branch_taken = 1, jump_index = 26'h000_0100 → pc = 32'h1000_0400. Then jump_reg = 1 with jump = 1, jump_reg_addr = 32'h0000_0200 → pc = 32'h0000_0200.
- Misaligned JR: jump_reg_addr = 32'h0000_0102.
  - With PC_ALIGN_CHECK_EN: pc = 32'h0000_0080 and misalign_err pulses for 1 cycle.
  - Without it: pc = 32'h0000_0100 and misalign_err = 0.
- Reset mid-operation: assert rst in FETCH with pc = 32'h0000_0020, then an ack arrives the cycle after release → pc = 0, instr latched from address 0, retired_count = 0.
